// File: rtl/gray_sched.sv
// gray_sched -- two-requester round-robin scheduler for a shared gray counter.
//
// A requester is granted from IDLE, its step count (Len0/Len1) is captured on
// the grant edge, and the shared counter is enabled (En) for exactly that many
// RUN cycles. A single DONE cycle then pulses Done for the owner before the
// scheduler returns to IDLE. When both requesters contend, the one that did
// not own the previous grant wins; after reset requester 0 wins first.
// The owner dropping its request during RUN aborts the grant without Done.
//
// Ports:
//   Clk       in   rising-edge clock
//   Reset     in   synchronous, active-high reset
//   Req[1:0]  in   request levels, bit i = requester i
//   Len0[3:0] in   step count for requester 0, sampled on the grant edge
//   Len1[3:0] in   step count for requester 1, sampled on the grant edge
//   Overflow  in   overflow flag from the shared gray counter
//   Gnt[1:0]  out  one-hot grant, 0 when idle
//   Done[1:0] out  one-cycle completion pulse to the owner
//   En        out  shared counter enable, high only in RUN
//   Busy      out  high whenever the scheduler is not idle
//
// Build option: define GRAY_SCHED_OVF_STOP_EN to let a rising Overflow during
// RUN end the grant early (normal Done pulse). Without it Overflow is ignored.

module gray_sched (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [1:0] Req,
   input  logic [3:0] Len0,
   input  logic [3:0] Len1,
   input  logic       Overflow,
   output logic [1:0] Gnt,
   output logic [1:0] Done,
   output logic       En,
   output logic       Busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_reg, state_next;
   logic [3:0] remain_reg, remain_next;
   logic       owner_reg, owner_next;
   logic       last_reg, last_next;
   logic [1:0] gnt_reg, gnt_next;

   logic       pick;
   logic [3:0] pick_len;
   logic       stop_early;

`ifdef GRAY_SCHED_OVF_STOP_EN
   // Previous Overflow value; the rise is seen in the same cycle Overflow
   // goes high, so RUN ends at the edge closing that cycle.
   logic ovf_reg;

   always_ff @(posedge Clk) begin
      ovf_reg <= Overflow;
   end

   assign stop_early = Overflow & ~ovf_reg;
`else
   logic unused_overflow;
   assign unused_overflow = Overflow;
   assign stop_early      = 1'b0;
`endif

   // Single requester wins outright; on contention the one that was not
   // the last owner wins.
   assign pick     = (Req == 2'b11) ? ~last_reg : Req[1];
   assign pick_len = pick ? Len1 : Len0;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg  <= IDLE;
         remain_reg <= 4'd0;
         owner_reg  <= 1'b0;
         last_reg   <= 1'b1;
         gnt_reg    <= 2'b00;
      end else begin
         state_reg  <= state_next;
         remain_reg <= remain_next;
         owner_reg  <= owner_next;
         last_reg   <= last_next;
         gnt_reg    <= gnt_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      remain_next = remain_reg;
      owner_next  = owner_reg;
      last_next   = last_reg;
      gnt_next    = gnt_reg;

      case (state_reg)
         IDLE: begin
            if (Req != 2'b00) begin
               owner_next  = pick;
               gnt_next    = pick ? 2'b10 : 2'b01;
               remain_next = pick_len;
               // A zero-length grant skips RUN and only produces Done.
               state_next  = (pick_len == 4'd0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (!Req[owner_reg]) begin
               // Owner withdrew: abort silently, no Done pulse.
               state_next  = IDLE;
               gnt_next    = 2'b00;
               last_next   = owner_reg;
               remain_next = 4'd0;
            end else begin
               remain_next = remain_reg - 4'd1;
               if ((remain_reg == 4'd1) || stop_early) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
            gnt_next   = 2'b00;
            last_next  = owner_reg;
         end
         default: begin
            state_next = IDLE;
            gnt_next   = 2'b00;
         end
      endcase
   end

   assign Gnt  = gnt_reg;
   assign En   = (state_reg == RUN);
   assign Busy = (state_reg != IDLE);

   // Done is decoded from the owner so it can only ever be one-hot.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_done
         assign Done[gi] = (state_reg == DONE) && (owner_reg == 1'(gi));
      end
   endgenerate

endmodule

// File: tb/tb_gray_sched.sv
// Self-checking bench for gray_sched. A negedge monitor turns each grant
// (Gnt going non-zero until it returns to zero) into a transaction record;
// each scenario pushes its expected transactions when it drives stimulus
// and compares them against the monitored ones.

module tb_gray_sched;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic [1:0] Req = 2'b00;
   logic [3:0] Len0 = 4'd0;
   logic [3:0] Len1 = 4'd0;
   logic       Overflow = 1'b0;
   logic [1:0] Gnt;
   logic [1:0] Done;
   logic       En;
   logic       Busy;

   gray_sched dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Req      (Req),
      .Len0     (Len0),
      .Len1     (Len1),
      .Overflow (Overflow),
      .Gnt      (Gnt),
      .Done     (Done),
      .En       (En),
      .Busy     (Busy)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [1:0] gnt;
      int         en;
      int         dn;
      logic [1:0] dv;
      int         dur;
      int         start;
      int         stop;
   } txn_t;

   txn_t exp_q[$];
   txn_t obs_q[$];
   int   checks = 0;
   int   errors = 0;
   int   viol   = 0;
   int   cyc    = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   // Monitor: builds one record per grant, flags per-cycle invariant breaks.
   initial begin
      txn_t cur;
      bit   active;
      active = 1'b0;
      cur = '{gnt: 2'b00, en: 0, dn: 0, dv: 2'b00, dur: 0, start: 0, stop: 0};
      forever begin
         @(negedge Clk);
         if (active && (Gnt !== cur.gnt)) begin
            cur.stop = cyc;
            obs_q.push_back(cur);
            active = 1'b0;
            $display("txn: gnt=%b en=%0d done=%0d/%b dur=%0d start=%0d", cur.gnt, cur.en, cur.dn, cur.dv, cur.dur, cur.start);
         end
         if (!active && (Gnt != 2'b00)) begin
            active = 1'b1;
            cur = '{gnt: Gnt, en: 0, dn: 0, dv: 2'b00, dur: 0, start: cyc, stop: 0};
         end
         if (active) begin
            if (En) cur.en = cur.en + 1;
            if (Done != 2'b00) begin
               cur.dn = cur.dn + 1;
               cur.dv = cur.dv | Done;
            end
            cur.dur = cur.dur + 1;
         end
         if ((En && Gnt == 2'b00) || (Done != 2'b00 && Done !== Gnt) || Gnt == 2'b11 ||
             (Busy !== (Gnt != 2'b00)) || (En && Done != 2'b00)) begin
            viol = viol + 1;
            $display("invariant broken at cycle %0d: Gnt=%b Done=%b En=%b Busy=%b", cyc, Gnt, Done, En, Busy);
         end
      end
   end

   function automatic string fmt(input txn_t t);
      return $sformatf("gnt=%b en=%0d done=%0d/%b dur=%0d", t.gnt, t.en, t.dn, t.dv, t.dur);
   endfunction

   task automatic push_exp(input logic [1:0] g, input int en, input int dn, input int dur);
      txn_t t;
      t = '{gnt: g, en: en, dn: dn, dv: (dn > 0) ? g : 2'b00, dur: dur, start: 0, stop: 0};
      exp_q.push_back(t);
   endtask

   task automatic pop_pair(output txn_t e, output txn_t o);
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      else o = '{gnt: 2'bxx, en: -1, dn: -1, dv: 2'bxx, dur: -1, start: 0, stop: 0};
   endtask

   task automatic clear_q();
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      Req   = 2'b00;
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;
   endtask

   task automatic wait_done(input int n, output bit ok);
      int seen;
      seen = 0;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge Clk);
         if (Done != 2'b00) seen++;
         if (seen >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_en(input int n, input logic [1:0] mask, output bit ok);
      int seen;
      seen = 0;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge Clk);
         if (En && ((Gnt & mask) != 2'b00)) seen++;
         if (seen >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_obs(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (obs_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
         @(negedge Clk);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      Req   = 2'b11;
      Len0  = 4'd5;
      Len1  = 4'd5;
      for (int i = 0; i < 2; i++) begin
         @(negedge Clk);
         checks++;
         if ({Gnt, Done, En, Busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs%0d: got Gnt=%b Done=%b En=%b Busy=%b, required all 0", i, Gnt, Done, En, Busy);
         end
      end
      @(posedge Clk);
      #1 Reset = 1'b0;
      Req = 2'b00;
   endtask

   task automatic test_basic();
      bit ok;
      txn_t e, o;
      clear_q();
      Len0 = 4'd3;
      Req  = 2'b01;
      push_exp(2'b01, 3, 1, 4);
      wait_done(1, ok);
      Req = 2'b00;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL basic_done_timeout: got no Done pulse, required one");
      end
      wait_obs(1, ok);
      pop_pair(e, o);
      checks++;
      if (o.gnt !== e.gnt || o.en != e.en || o.dn != e.dn || o.dv !== e.dv || o.dur != e.dur) begin
         errors++;
         $display("FAIL basic_txn: got %s, required %s", fmt(o), fmt(e));
      end
      repeat (3) @(negedge Clk);
      checks++;
      if (obs_q.size() != 0 || Gnt !== 2'b00 || Busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_idle: got extra=%0d Gnt=%b Busy=%b, required 0 0 0", obs_q.size(), Gnt, Busy);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      txn_t e, o;
      txn_t got[4];
      do_reset();
      clear_q();
      Len0 = 4'd2;
      Len1 = 4'd4;
      Req  = 2'b11;
      push_exp(2'b01, 2, 1, 3);
      push_exp(2'b10, 4, 1, 5);
      push_exp(2'b01, 2, 1, 3);
      push_exp(2'b10, 4, 1, 5);
      wait_done(4, ok);
      Req = 2'b00;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL b2b_done_timeout: got fewer than 4 Done pulses, required 4");
      end
      wait_obs(4, ok);
      for (int i = 0; i < 4; i++) begin
         pop_pair(e, o);
         got[i] = o;
         checks++;
         if (o.gnt !== e.gnt || o.en != e.en || o.dn != e.dn || o.dv !== e.dv || o.dur != e.dur) begin
            errors++;
            $display("FAIL b2b_txn%0d: got %s, required %s", i, fmt(o), fmt(e));
         end
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (got[i+1].start - got[i].stop != 1) begin
            errors++;
            $display("FAIL b2b_gap%0d: got %0d idle cycles, required 1", i, got[i+1].start - got[i].stop);
         end
      end
      repeat (3) @(negedge Clk);
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_extra: got %0d extra grants, required 0", obs_q.size());
      end
   endtask

   task automatic test_zero_len();
      bit ok;
      txn_t e, o;
      clear_q();
      Len1 = 4'd0;
      Req  = 2'b10;
      push_exp(2'b10, 0, 1, 1);
      wait_done(1, ok);
      Req = 2'b00;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL zero_done_timeout: got no Done pulse, required one");
      end
      wait_obs(1, ok);
      pop_pair(e, o);
      checks++;
      if (o.gnt !== e.gnt || o.en != e.en || o.dn != e.dn || o.dv !== e.dv || o.dur != e.dur) begin
         errors++;
         $display("FAIL zero_txn: got %s, required %s", fmt(o), fmt(e));
      end
   endtask

   task automatic test_nonowner();
      bit ok;
      txn_t e, o;
      clear_q();
      Len0 = 4'd3;
      Len1 = 4'd5;
      Req  = 2'b01;
      push_exp(2'b01, 3, 1, 4);
      push_exp(2'b10, 5, 1, 6);
      wait_en(1, 2'b11, ok);
      // Mid-run: requester 1 joins and Len0 changes; neither may disturb the owner.
      Req  = 2'b11;
      Len0 = 4'd9;
      wait_done(2, ok);
      Req = 2'b00;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL nonowner_timeout: got fewer than 2 Done pulses, required 2");
      end
      wait_obs(2, ok);
      for (int i = 0; i < 2; i++) begin
         pop_pair(e, o);
         checks++;
         if (o.gnt !== e.gnt || o.en != e.en || o.dn != e.dn || o.dv !== e.dv || o.dur != e.dur) begin
            errors++;
            $display("FAIL nonowner_txn%0d: got %s, required %s", i, fmt(o), fmt(e));
         end
      end
   endtask

   task automatic test_abort();
      bit ok;
      txn_t e, o;
      clear_q();
      Len0 = 4'd15;
      Req  = 2'b01;
      push_exp(2'b01, 5, 0, 5);
      wait_en(5, 2'b11, ok);
      Req = 2'b00;
      @(negedge Clk);
      checks++;
      if (!ok || En !== 1'b0 || Gnt !== 2'b00 || Done !== 2'b00) begin
         errors++;
         $display("FAIL abort_outputs: got ok=%0d En=%b Gnt=%b Done=%b, required ok=1 En=0 Gnt=00 Done=00", ok, En, Gnt, Done);
      end
      wait_obs(1, ok);
      pop_pair(e, o);
      checks++;
      if (o.gnt !== e.gnt || o.en != e.en || o.dn != e.dn || o.dv !== e.dv || o.dur != e.dur) begin
         errors++;
         $display("FAIL abort_txn: got %s, required %s", fmt(o), fmt(e));
      end
   endtask

   task automatic test_reset_run();
      bit ok;
      txn_t e, o;
      do_reset();
      clear_q();
      Len0 = 4'd1;
      Len1 = 4'd10;
      Req  = 2'b11;
      push_exp(2'b01, 1, 1, 2);
      push_exp(2'b10, 4, 0, 4);
      push_exp(2'b01, 1, 1, 2);
      // Fourth En cycle of requester 1 has Remain=7.
      wait_en(4, 2'b10, ok);
      Reset = 1'b1;
      @(negedge Clk);
      checks++;
      if (!ok || {Gnt, Done, En, Busy} !== 6'b0) begin
         errors++;
         $display("FAIL reset_run_outputs: got ok=%0d Gnt=%b Done=%b En=%b Busy=%b, required ok=1 all 0", ok, Gnt, Done, En, Busy);
      end
      Reset = 1'b0;
      wait_done(1, ok);
      Req = 2'b00;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL reset_run_timeout: got no Done after reset, required one");
      end
      wait_obs(3, ok);
      for (int i = 0; i < 3; i++) begin
         pop_pair(e, o);
         checks++;
         if (o.gnt !== e.gnt || o.en != e.en || o.dn != e.dn || o.dv !== e.dv || o.dur != e.dur) begin
            errors++;
            $display("FAIL reset_run_txn%0d: got %s, required %s", i, fmt(o), fmt(e));
         end
      end
   endtask

   task automatic test_overflow();
      bit ok;
      int exp_en;
      txn_t e, o;
      clear_q();
`ifdef GRAY_SCHED_OVF_STOP_EN
      exp_en = 5;
`else
      exp_en = 10;
`endif
      Len0     = 4'd10;
      Overflow = 1'b0;
      Req      = 2'b01;
      push_exp(2'b01, exp_en, 1, exp_en + 1);
      wait_en(4, 2'b11, ok);
      @(posedge Clk);
      #1 Overflow = 1'b1;
      wait_done(1, ok);
      Req      = 2'b00;
      Overflow = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL ovf_timeout: got no Done pulse, required one");
      end
      wait_obs(1, ok);
      pop_pair(e, o);
      checks++;
      if (o.gnt !== e.gnt || o.en != e.en || o.dn != e.dn || o.dv !== e.dv || o.dur != e.dur) begin
         errors++;
         $display("FAIL ovf_txn: got %s, required %s", fmt(o), fmt(e));
      end
   endtask

   task automatic test_invariants();
      repeat (3) @(negedge Clk);
      checks++;
      if (viol != 0 || obs_q.size() != 0) begin
         errors++;
         $display("FAIL invariants: got %0d broken cycles and %0d stray grants, required 0 and 0", viol, obs_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_zero_len();
      test_nonowner();
      test_abort();
      test_reset_run();
      test_overflow();
      test_invariants();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
